// File: rtl/nv_nvdla_cmac_accu_pd_gen_if.sv
// rtl/nv_nvdla_cmac_accu_pd_gen_if.sv - register, MAC beat and mac2accu sideband bundle
interface nv_nvdla_cmac_accu_pd_gen_if #(
  parameter int ABUF_AWIDTH = 6,
  parameter int CNT_W       = 13
);
  logic                   reg2dp_op_en;
  logic [ABUF_AWIDTH-1:0] reg2dp_stripe_len_m1;
  logic [CNT_W-1:0]       reg2dp_stripe_num_m1;
  logic [CNT_W-1:0]       reg2dp_group_num_m1;
  logic                   mac_out_pvld;
  logic                   mac2accu_pvld;
  logic [8:0]             mac2accu_pd;
  logic                   layer_done;
  logic                   wait_for_op_en;
  logic                   err_beat_idle;

  // Driver side: register file and MAC array
  modport master (
    output reg2dp_op_en, reg2dp_stripe_len_m1, reg2dp_stripe_num_m1,
           reg2dp_group_num_m1, mac_out_pvld,
    input  mac2accu_pvld, mac2accu_pd, layer_done, wait_for_op_en, err_beat_idle
  );

  // Packet generator side
  modport slave (
    input  reg2dp_op_en, reg2dp_stripe_len_m1, reg2dp_stripe_num_m1,
           reg2dp_group_num_m1, mac_out_pvld,
    output mac2accu_pvld, mac2accu_pd, layer_done, wait_for_op_en, err_beat_idle
  );
endinterface

// File: rtl/nv_nvdla_cmac_accu_pd_gen.sv
// rtl/nv_nvdla_cmac_accu_pd_gen.sv - mac2accu sideband packet generator with per-layer beat counting
module nv_nvdla_cmac_accu_pd_gen #(
  parameter int ABUF_AWIDTH = 6,
  parameter int CNT_W       = 13
) (
  input  logic                             nvdla_core_clk,
  input  logic                             nvdla_core_rstn,
  nv_nvdla_cmac_accu_pd_gen_if.slave       io
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]             state;
  logic [ABUF_AWIDTH-1:0] cfg_stripe_len_m1;
  logic [CNT_W-1:0]       cfg_stripe_num_m1;
  logic [CNT_W-1:0]       cfg_group_num_m1;
  logic [ABUF_AWIDTH-1:0] atom_cnt;
  logic [CNT_W-1:0]       stripe_cnt;
  logic [CNT_W-1:0]       group_cnt;
  logic                   pvld_q;
  logic [8:0]             pd_q;
  logic                   layer_done_q;
  logic                   wait_q;
  logic                   err_q;

  logic                   layer_st;
  logic                   accept;
  logic [ABUF_AWIDTH-1:0] eff_len_m1;
  logic [CNT_W-1:0]       eff_num_m1;
  logic [CNT_W-1:0]       eff_grp_m1;
  logic [ABUF_AWIDTH-1:0] cur_atom;
  logic [CNT_W-1:0]       cur_stripe;
  logic [CNT_W-1:0]       cur_group;
  logic                   stripe_st;
  logic                   stripe_end;
  logic                   channel_end;
  logic                   layer_end;

  // A beat landing in the layer_st cycle is the first beat: use live geometry and zeroed counters
  always_comb begin
    layer_st    = (state == IDLE) & wait_q & io.reg2dp_op_en;
    accept      = io.mac_out_pvld & (layer_st | (state == RUN));
    eff_len_m1  = layer_st ? io.reg2dp_stripe_len_m1 : cfg_stripe_len_m1;
    eff_num_m1  = layer_st ? io.reg2dp_stripe_num_m1 : cfg_stripe_num_m1;
    eff_grp_m1  = layer_st ? io.reg2dp_group_num_m1  : cfg_group_num_m1;
    cur_atom    = layer_st ? '0 : atom_cnt;
    cur_stripe  = layer_st ? '0 : stripe_cnt;
    cur_group   = layer_st ? '0 : group_cnt;
    stripe_st   = (cur_atom == '0);
    stripe_end  = (cur_atom == eff_len_m1);
    channel_end = stripe_end & (cur_stripe == eff_num_m1);
    layer_end   = channel_end & (cur_group == eff_grp_m1);
  end

  // Layer FSM and geometry latch
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state             <= IDLE;
      cfg_stripe_len_m1 <= '0;
      cfg_stripe_num_m1 <= '0;
      cfg_group_num_m1  <= '0;
    end else begin
      if (layer_st) begin
        cfg_stripe_len_m1 <= io.reg2dp_stripe_len_m1;
        cfg_stripe_num_m1 <= io.reg2dp_stripe_num_m1;
        cfg_group_num_m1  <= io.reg2dp_group_num_m1;
      end
      case (state)
        IDLE:    if (layer_st) state <= (accept & layer_end) ? DONE : RUN;
        RUN:     if (accept & layer_end) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Atom/stripe/group counters advance on accepted beats and clear at layer boundaries
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      atom_cnt   <= '0;
      stripe_cnt <= '0;
      group_cnt  <= '0;
    end else if (accept) begin
      if (layer_end) begin
        atom_cnt   <= '0;
        stripe_cnt <= '0;
        group_cnt  <= '0;
      end else begin
        atom_cnt   <= stripe_end ? '0 : cur_atom + 1'b1;
        stripe_cnt <= channel_end ? '0 : (stripe_end ? cur_stripe + 1'b1 : cur_stripe);
        group_cnt  <= channel_end ? cur_group + 1'b1 : cur_group;
      end
    end else if (layer_st) begin
      atom_cnt   <= '0;
      stripe_cnt <= '0;
      group_cnt  <= '0;
    end
  end

  // Registered packet and status outputs; pd holds between valid beats
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      pvld_q       <= 1'b0;
      pd_q         <= '0;
      layer_done_q <= 1'b0;
      wait_q       <= 1'b1;
      err_q        <= 1'b0;
    end else begin
      pvld_q       <= accept;
      layer_done_q <= accept & layer_end;
      if (accept)
        pd_q <= {layer_end, channel_end, stripe_end, stripe_st, 5'b0};
      if (accept & layer_end)
        wait_q <= 1'b1;
      else if (layer_st)
        wait_q <= 1'b0;
      if (layer_st)
        err_q <= 1'b0;
      else if (io.mac_out_pvld & (state != RUN))
        err_q <= 1'b1;
    end
  end

  assign io.mac2accu_pvld  = pvld_q;
  assign io.mac2accu_pd    = pd_q;
  assign io.layer_done     = layer_done_q;
  assign io.wait_for_op_en = wait_q;
  assign io.err_beat_idle  = err_q;

endmodule

// File: tb/tb_nv_nvdla_cmac_accu_pd_gen.sv
// tb/tb_nv_nvdla_cmac_accu_pd_gen.sv - scoreboard bench for the mac2accu packet generator
module tb_nv_nvdla_cmac_accu_pd_gen;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  nv_nvdla_cmac_accu_pd_gen_if #(.ABUF_AWIDTH(6), .CNT_W(13)) bus ();

  nv_nvdla_cmac_accu_pd_gen #(.ABUF_AWIDTH(6), .CNT_W(13)) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .io              (bus.slave)
  );

  int         n_vec = 0;
  int         n_err = 0;
  logic [8:0] exp_q[$];
  int         g_len, g_num, g_grp;
  int         k;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected flags derived from the beat's position in the layer
  function automatic logic [8:0] exp_pd(input int idx);
    int a, s, g;
    logic st, se, ce, le;
    a  = idx % (g_len + 1);
    s  = (idx / (g_len + 1)) % (g_num + 1);
    g  = idx / ((g_len + 1) * (g_num + 1));
    st = (a == 0);
    se = (a == g_len);
    ce = se && (s == g_num);
    le = ce && (g == g_grp);
    return {le, ce, se, st, 5'b0};
  endfunction

  task automatic set_geom(input int len, input int num, input int grp);
    g_len = len; g_num = num; g_grp = grp; k = 0;
    bus.reg2dp_stripe_len_m1 = 6'(len);
    bus.reg2dp_stripe_num_m1 = 13'(num);
    bus.reg2dp_group_num_m1  = 13'(grp);
  endtask

  // One clock: drive at negedge, check the registered response at the next negedge
  task automatic cycle(input bit pv, input bit beat, input bit op);
    logic [8:0] e;
    e = '0;
    bus.mac_out_pvld = pv;
    bus.reg2dp_op_en = op;
    if (beat) begin
      exp_q.push_back(exp_pd(k));
      k++;
    end
    @(posedge clk);
    @(negedge clk);
    chk("pvld", 16'(bus.mac2accu_pvld), 16'(beat));
    if (beat && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk($sformatf("pd[%0d]", k - 1), 16'(bus.mac2accu_pd), 16'(e));
    end
    chk("layer_done", 16'(bus.layer_done), 16'(e[8]));
    bus.mac_out_pvld = 1'b0;
    bus.reg2dp_op_en = 1'b0;
  endtask

  initial begin
    bus.reg2dp_op_en = 1'b0;
    bus.mac_out_pvld = 1'b0;
    set_geom(0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_pvld", 16'(bus.mac2accu_pvld), 16'h0);
    chk("rst_pd", 16'(bus.mac2accu_pd), 16'h0);
    chk("rst_done", 16'(bus.layer_done), 16'h0);
    chk("rst_wait", 16'(bus.wait_for_op_en), 16'h1);
    chk("rst_err", 16'(bus.err_beat_idle), 16'h0);
    rstn = 1'b1;
    @(negedge clk);

    // 4-atom stripes, 2 stripes, 1 group, back-to-back
    set_geom(3, 1, 0);
    cycle(0, 0, 1);
    chk("t1_wait_low", 16'(bus.wait_for_op_en), 16'h0);
    for (int i = 0; i < 8; i++) cycle(1, 1, 0);
    chk("t1_wait_high", 16'(bus.wait_for_op_en), 16'h1);
    cycle(0, 0, 0);

    // Single-atom stripes, 3 groups, beats with gaps
    set_geom(0, 0, 2);
    cycle(0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, 0);
      if (i < 2) cycle(0, 0, 0);
    end
    // Beat during DONE is dropped and flagged
    cycle(1, 0, 0);
    chk("t2_err_done", 16'(bus.err_beat_idle), 16'h1);
    // Beat during IDLE is dropped and flagged
    cycle(1, 0, 0);
    chk("t5_err_idle", 16'(bus.err_beat_idle), 16'h1);
    chk("t5_wait", 16'(bus.wait_for_op_en), 16'h1);

    // Max stripe length, 128 beats; layer start clears the sticky error
    set_geom(63, 1, 0);
    cycle(0, 0, 1);
    chk("t3_err_clr", 16'(bus.err_beat_idle), 16'h0);
    for (int i = 0; i < 128; i++) cycle(1, 1, 0);
    cycle(0, 0, 0);

    // op_en with first beat in the same cycle; config change mid-layer ignored
    set_geom(1, 0, 1);
    cycle(1, 1, 1);
    bus.reg2dp_stripe_len_m1 = 6'd0;
    bus.reg2dp_stripe_num_m1 = 13'd3;
    bus.reg2dp_group_num_m1  = 13'd5;
    for (int i = 0; i < 3; i++) cycle(1, 1, 0);
    chk("t4_wait_high", 16'(bus.wait_for_op_en), 16'h1);
    cycle(0, 0, 0);

    // Reset after 5 of 8 beats, then a clean restart
    set_geom(3, 1, 0);
    cycle(0, 0, 1);
    for (int i = 0; i < 5; i++) cycle(1, 1, 0);
    rstn = 1'b0;
    #2;
    chk("t6_rst_pvld", 16'(bus.mac2accu_pvld), 16'h0);
    chk("t6_rst_pd", 16'(bus.mac2accu_pd), 16'h0);
    chk("t6_rst_wait", 16'(bus.wait_for_op_en), 16'h1);
    chk("t6_rst_err", 16'(bus.err_beat_idle), 16'h0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    set_geom(3, 1, 0);
    cycle(0, 0, 1);
    for (int i = 0; i < 8; i++) cycle(1, 1, 0);
    chk("t6_wait_high", 16'(bus.wait_for_op_en), 16'h1);
    cycle(0, 0, 0);
    chk("t6_done_low", 16'(bus.layer_done), 16'h0);
    chk("sb_empty", 16'(exp_q.size()), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
